// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 CHIP-8 keypad, debounces each key and reports new presses
module keypad_scanner #(
  parameter int SCAN_DIV = 64,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row_drive,
  input  logic [3:0]  col_sense,
  output logic [15:0] keypad_matrix,
  output logic        key_press,
  output logic [3:0]  key_code
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
  localparam logic [63:0] KMAP = 64'hFB0A_E987_D654_C321;
  logic [3:0] sync1, sync2, col_s;
  logic [DW-1:0] div;
  logic [1:0] row;
  logic sample;
  logic [3:0] key [4];
  logic [CW-1:0] cnt [16];
  logic [CW-1:0] cnt_n [16];
  logic [15:0] mat_n;
  logic rise_n, rise_q;
  logic [3:0] code_n, code_q;
  function automatic logic [3:0] kmap(input logic [3:0] p);
    return KMAP[{p, 2'b00} +: 4];
  endfunction
  assign col_s = ~sync2;
  assign sample = div == DIV_MAX;
  // column synchronizer and row scan; row_drive moves together with row
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      div <= '0;
      row <= '0;
      row_drive <= 4'b1110;
    end else begin
      sync1 <= col_sense;
      sync2 <= sync1;
      div <= sample ? '0 : div + 1'b1;
      if (sample) begin
        row <= row + 2'd1;
        row_drive <= ~(4'b0001 << (row + 2'd1));
      end
    end
  // CHIP-8 codes of the four keys in the current row
  always_comb
    for (int c = 0; c < 4; c++) key[c] = kmap({row, 2'(c)});
  // debounce the sampled row and pick the lowest newly pressed code
  always_comb begin
    mat_n = keypad_matrix;
    cnt_n = cnt;
    rise_n = 1'b0;
    code_n = 4'hF;
    if (sample)
      for (int c = 0; c < 4; c++)
        if (col_s[c] == keypad_matrix[key[c]]) cnt_n[key[c]] = '0;
        else if (cnt[key[c]] == CNT_MAX) begin
          mat_n[key[c]] = col_s[c];
          cnt_n[key[c]] = '0;
          if (col_s[c] && key[c] <= code_n) begin
            rise_n = 1'b1;
            code_n = key[c];
          end
        end else cnt_n[key[c]] = cnt[key[c]] + 1'b1;
  end
  // key state, counters, and a press pulse one clock after the matrix bit sets
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      keypad_matrix <= '0;
      cnt <= '{default: '0};
      rise_q <= 1'b0;
      code_q <= '0;
      key_press <= 1'b0;
      key_code <= '0;
    end else begin
      keypad_matrix <= mat_n;
      cnt <= cnt_n;
      rise_q <= rise_n;
      code_q <= code_n;
      key_press <= rise_q;
      if (rise_q) key_code <= code_q;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: emulated keypad with a cycle-level reference model and press scoreboard
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam logic [3:0] KEYS [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };
  typedef struct {int code; int at;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] row_drive, col_sense, key_code, pulled;
  logic [3:0] force_low = 4'h0;
  logic [15:0] keypad_matrix;
  logic [15:0] held = 16'h0;
  logic key_press;
  int n_chk = 0;
  int n_pass = 0;
  int n;
  int m_cnt [16];
  int p_at, p_code;
  logic [15:0] m_mat;
  logic [3:0] h1, h2, m_code;
  ev_t q [$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .reset(reset), .row_drive(row_drive), .col_sense(col_sense),
    .keypad_matrix(keypad_matrix), .key_press(key_press), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // keypad emulation: a held key pulls its column low while its row is driven
  always_comb begin
    pulled = force_low;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_drive[r] && held[KEYS[r][c]]) pulled[c] = 1'b1;
    col_sense = ~pulled;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, n);
  endtask

  // reference model: clocks since reset, sample every SD clocks, column seen two clocks late
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; m_mat = '0; h1 = 4'hF; h2 = 4'hF; m_code = '0; p_at = -1; p_code = 0;
      for (int k = 0; k < 16; k++) m_cnt[k] = 0;
      q.delete();
    end else begin
      int r, best, k;
      logic s;
      n++;
      if (n == p_at) m_code = 4'(p_code);
      if (n % SD == 0) begin
        r = ((n - 1) / SD) % 4;
        best = 16;
        for (int c = 0; c < 4; c++) begin
          k = KEYS[r][c];
          s = ~h2[c];
          if (s == m_mat[k]) m_cnt[k] = 0;
          else begin
            m_cnt[k]++;
            if (m_cnt[k] == DB) begin
              m_mat[k] = s;
              m_cnt[k] = 0;
              if (s && k < best) best = k;
            end
          end
        end
        if (best < 16) begin
          p_code = best;
          p_at = n + 1;
          q.push_back('{code: best, at: n + 1});
        end
      end
      h2 = h1;
      h1 = col_sense;
    end
  end

  // monitor: continuous output comparison and press scoreboard
  always @(negedge clk) begin
    ev_t e;
    chk("row_drive", 32'(row_drive), 32'(4'(~(4'b0001 << ((n / SD) % 4)))));
    chk("matrix", 32'(keypad_matrix), 32'(m_mat));
    chk("key_code_hold", 32'(key_code), 32'(m_code));
    if (key_press) begin
      if (q.size() == 0) chk("press_unexpected", 32'(key_press), 32'd0);
      else begin
        e = q.pop_front();
        chk("press_cycle", n, e.at);
        chk("press_code", 32'(key_code), e.code);
      end
    end else if (q.size() > 0 && q[0].at < n) begin
      q.delete(0);
      chk("press_missed", 32'(key_press), 32'd1);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_row_drive", 32'(row_drive), 32'(4'b1110));
    chk("rst_matrix", 32'(keypad_matrix), 32'd0);
    chk("rst_press", 32'(key_press), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("scan_order", 32'(row_drive), 32'(rows[i % 4]));
      wait_neg(SD);
    end
    // single key 5 press and release
    held = 16'h0020;
    do_reset();
    wait_neg(39);
    chk("key5_before", 32'(keypad_matrix), 32'd0);
    wait_neg(1);
    chk("key5_set", 32'(keypad_matrix), 32'h0020);
    wait_neg(1);
    chk("key5_pulse", 32'(key_press), 32'd1);
    chk("key5_code", 32'(key_code), 32'h5);
    wait_neg(1);
    chk("key5_pulse_end", 32'(key_press), 32'd0);
    held = 16'h0;
    wait_neg(48);
    chk("key5_release", 32'(keypad_matrix), 32'd0);
    // mid-frame reset with non-zero key_code
    wait_neg(5);
    do_reset();
    // bounce: key present on alternate frames only
    for (int i = 0; i < 6; i++) begin
      held = 16'h0020;
      wait_neg(4 * SD);
      held = 16'h0;
      wait_neg(4 * SD);
    end
    chk("bounce_matrix", 32'(keypad_matrix), 32'd0);
    // two keys in row3 at once
    do_reset();
    held = 16'h0C00;
    wait_neg(50);
    chk("dual_matrix", 32'(keypad_matrix), 32'h0C00);
    chk("dual_code", 32'(key_code), 32'hA);
    // row selectivity
    held = 16'h0;
    do_reset();
    held = 16'h0080;
    wait_neg(60);
    chk("row2_only", 32'(keypad_matrix), 32'h0080);
    held = 16'h0;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 16 && n % 16 != 0; i++) @(negedge clk);
      force_low = 4'b0001;
      @(negedge clk) force_low = 4'b0000;
      wait_neg(2);
    end
    wait_neg(8);
    chk("glitch_ignored", 32'(keypad_matrix), 32'd0);
    // reset after two of three samples
    held = 16'h0020;
    do_reset();
    wait_neg(30);
    do_reset();
    wait_neg(39);
    chk("rst_debounce_hold", 32'(keypad_matrix), 32'd0);
    wait_neg(1);
    chk("rst_debounce_set", 32'(keypad_matrix), 32'h0020);
    // random key activity against the model
    held = 16'h0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      held = 16'($urandom) & 16'($urandom) & 16'($urandom);
      wait_neg($urandom_range(4, 80));
    end
    held = 16'h0;
    wait_neg(80);
    chk("press_pending", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
